iso_lane_mapper: RTL
====================

# iso_lane_mapper

Parametrised lane mapper for the isochronous link path. It buffers full-width symbol beats from the ISO packer and deals them, in sequence order, across 1, 2, 4 … LANES_MAX active lanes. Every link clock it emits one symbol per active lane. When the buffer runs dry it inserts a fill symbol. It sits between the ISO packer and the per-lane scramblers/encoders, and replaces the fixed 4-lane fan-out with a configurable lane count, depth and width.

## Interface
- LANES_MAX, 4: maximum lane count; power of two, ≥1.
- SYM_W, 8: symbol width in bits.
- DEPTH, 8: beat FIFO depth; power of two, ≥2.
- FILL_SYM, 8'h00: symbol emitted on underflow, SYM_W bits.
- FILL_CTRL, 1'b0: control flag emitted with FILL_SYM.
- ls_clk  in  1  link symbol clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- iso_en  in  1  mapper enable; low flushes the FIFO and idles the lanes.
- cfg_lane_count  in  $clog2(LANES_MAX)+1  active lanes; legal values are 1, 2, 4 … LANES_MAX.
- in_sym  in  LANES_MAX*SYM_W  beat; symbol k is in bits [k*SYM_W +: SYM_W], and k=0 is the oldest.
- in_ctrl  in  LANES_MAX  control flag per symbol of the beat.
- in_vld  in  1  beat valid.
- in_rdy  out  1  beat accepted when in_vld && in_rdy at a rising edge.
- lane_sym  out  LANES_MAX*SYM_W  per-lane output symbol; lane l is in bits [l*SYM_W +: SYM_W].
- lane_ctrl  out  LANES_MAX  per-lane control flag.
- lane_vld  out  1  lanes carry live or fill symbols this cycle.
- fill_active  out  1  the current output is a fill symbol.
- underflow  out  1  sticky; set on any fill while running; cleared by reset or by iso_en low.
- fifo_level  out  $clog2(DEPTH)+1  beats held in the FIFO.

## Operation
- States:
  - IDLE: iso_en=0.
  - RUN.
- IDLE→RUN on the first edge with iso_en=1. At that edge cfg_lane_count is latched into lc. lc is held for the whole of RUN; changes to cfg_lane_count during RUN are ignored.
- RUN→IDLE on any edge with iso_en=0. Effects:
  - FIFO pointers and fifo_level are cleared; sub is cleared.
  - underflow is cleared.
  - All outputs are zeroed from the next edge.
- Illegal lc (0, not a power of two, or >LANES_MAX) is treated as 1.
- FIFO behaviour:
  - DEPTH beats; in_rdy = iso_en && (fifo_level != DEPTH).
  - A push at full is refused even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle leave fifo_level unchanged.
- Drain: the sub-index sub runs 0 … (LANES_MAX/lc − 1). Each RUN cycle with the FIFO non-empty:
  - lanes l < lc load symbol head[sub*lc + l] and its ctrl flag;
  - sub increments;
  - on the last sub the head beat pops and sub wraps to 0.
- Lanes l ≥ lc always output 0 with ctrl 0.
- Underflow: in a RUN cycle with the FIFO empty, lanes l < lc load FILL_SYM/FILL_CTRL, fill_active=1, underflow sets, and sub is unchanged.
- Pointers wrap modulo DEPTH. fifo_level is the true count, 0 … DEPTH inclusive.

## Timing
- Reset values:
  - in_rdy=0, lane_sym=0, lane_ctrl=0, lane_vld=0, fill_active=0, underflow=0, fifo_level=0.
  - Internally: pointers=0, sub=0, state=IDLE.
- All outputs except in_rdy are registered. in_rdy is combinational from iso_en and fifo_level.
- Latency: a beat pushed at edge E into an empty FIFO drives its first lane slice from edge E+1.
- Throughput: one beat per LANES_MAX/lc cycles. At lc=LANES_MAX this is one beat per cycle with no bubble.
- lane_vld=1 in every cycle after the first RUN edge, and 0 from the edge after iso_en falls.
- Asynchronous reset mid-operation aborts immediately. No partial beat survives.

## Test plan
- Reset with in_vld=1 → all outputs 0; in_rdy=0 until iso_en=1.
- LANES_MAX=4, lc=1, one beat {S3,S2,S1,S0}={44,33,22,11} → lane0 shows 11, 22, 33, 44 on 4 consecutive cycles; lanes 1–3 = 0; fifo_level goes 1→0 after the 4th cycle.
- lc=2, two back-to-back beats {04,03,02,01}, {08,07,06,05} → lane0/lane1 show (01,02), (03,04), (05,06), (07,08), then FILL_SYM with fill_active=1 and underflow=1.
- lc=4, in_vld held high, drain stalled by holding iso_en=1 with continuous pushes at DEPTH=8 → fifo_level never exceeds 8; no beats lost or duplicated in an order check over 1000 beats.
- cfg_lane_count changed 4→1 mid-RUN → output keeps 4-lane mapping. Then iso_en low for one cycle and high → FIFO empty, underflow=0, new run uses 1 lane.
- Fill until full (iso_en high, lc=1), then simultaneous push attempt with pop → push refused, fifo_level stays 8 → 7 → 8 across the following edges.

Source files
------------

// File: rtl/iso_lane_mapper.sv
// Lane mapper: buffers full-width beats and deals them, in sequence order, across
// 1..LANES_MAX active lanes, inserting a fill symbol whenever the beat FIFO runs dry.
module iso_lane_mapper #(
    parameter int               LANES_MAX = 4,
    parameter int               SYM_W     = 8,
    parameter int               DEPTH     = 8,
    parameter logic [SYM_W-1:0] FILL_SYM  = 8'h00,
    parameter logic             FILL_CTRL = 1'b0
) (
    input  logic                           ls_clk,
    input  logic                           rst_n,
    input  logic                           iso_en,
    input  logic [$clog2(LANES_MAX):0]     cfg_lane_count,
    input  logic [LANES_MAX*SYM_W-1:0]     in_sym,
    input  logic [LANES_MAX-1:0]           in_ctrl,
    input  logic                           in_vld,
    output logic                           in_rdy,
    output logic [LANES_MAX*SYM_W-1:0]     lane_sym,
    output logic [LANES_MAX-1:0]           lane_ctrl,
    output logic                           lane_vld,
    output logic                           fill_active,
    output logic                           underflow,
    output logic [$clog2(DEPTH):0]         fifo_level
);

    localparam int LC_W  = $clog2(LANES_MAX) + 1;
    localparam int SUB_W = (LANES_MAX > 1) ? $clog2(LANES_MAX) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                       state_r;
    logic [LC_W-1:0]              lc_r;
    logic [SUB_W-1:0]             sub_r;
    logic [PTR_W-1:0]             wr_ptr_r;
    logic [PTR_W-1:0]             rd_ptr_r;
    logic [LANES_MAX*SYM_W-1:0]   mem_sym_r  [DEPTH];
    logic [LANES_MAX-1:0]         mem_ctrl_r [DEPTH];

    logic [LC_W-1:0]              lc_legal_s;
    logic                         push_s;
    logic                         empty_s;
    logic                         drain_s;
    logic                         last_sub_s;
    logic                         pop_s;
    logic [LANES_MAX*SYM_W-1:0]   head_sym_s;
    logic [LANES_MAX-1:0]         head_ctrl_s;
    logic [LANES_MAX*SYM_W-1:0]   map_sym_s;
    logic [LANES_MAX-1:0]         map_ctrl_s;

    // Illegal lane counts (zero, non power of two, too large) fall back to a single lane.
    always_comb begin
        lc_legal_s = LC_W'(1);
        if ((cfg_lane_count != LC_W'(0)) &&
            ((cfg_lane_count & (cfg_lane_count - LC_W'(1))) == LC_W'(0)) &&
            (cfg_lane_count <= LC_W'(LANES_MAX))) begin
            lc_legal_s = cfg_lane_count;
        end else begin
            lc_legal_s = LC_W'(1);
        end
    end

    // FIFO handshake and drain control; a full FIFO refuses a push even when it pops.
    always_comb begin
        in_rdy      = iso_en && (fifo_level != LVL_W'(DEPTH));
        push_s      = in_vld && in_rdy;
        empty_s     = (fifo_level == LVL_W'(0));
        drain_s     = (state_r == RUN) && iso_en && !empty_s;
        last_sub_s  = ((int'(sub_r) + 1) * int'(lc_r)) == LANES_MAX;
        pop_s       = drain_s && last_sub_s;
        head_sym_s  = mem_sym_r[rd_ptr_r];
        head_ctrl_s = mem_ctrl_r[rd_ptr_r];
    end

    // Lane l < lc takes head slot sub*lc + l, or the fill symbol when the FIFO is empty.
    always_comb begin
        map_sym_s  = '0;
        map_ctrl_s = '0;
        for (int l = 0; l < LANES_MAX; l++) begin
            if (l < int'(lc_r)) begin
                if (empty_s) begin
                    map_sym_s[l*SYM_W +: SYM_W] = FILL_SYM;
                    map_ctrl_s[l]               = FILL_CTRL;
                end else begin
                    map_sym_s[l*SYM_W +: SYM_W] =
                        head_sym_s[(int'(sub_r) * int'(lc_r) + l)*SYM_W +: SYM_W];
                    map_ctrl_s[l] = head_ctrl_s[int'(sub_r) * int'(lc_r) + l];
                end
            end else begin
                map_sym_s[l*SYM_W +: SYM_W] = '0;
                map_ctrl_s[l]               = 1'b0;
            end
        end
    end

    // Beat storage; contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge ls_clk) begin
        if (push_s) begin
            mem_sym_r[wr_ptr_r]  <= in_sym;
            mem_ctrl_r[wr_ptr_r] <= in_ctrl;
        end
    end

    // Mode FSM, FIFO pointers/level and registered lane outputs.
    always_ff @(posedge ls_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            lc_r        <= LC_W'(1);
            sub_r       <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            fifo_level  <= '0;
            lane_sym    <= '0;
            lane_ctrl   <= '0;
            lane_vld    <= 1'b0;
            fill_active <= 1'b0;
            underflow   <= 1'b0;
        end else if (!iso_en) begin
            state_r     <= IDLE;
            sub_r       <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            fifo_level  <= '0;
            lane_sym    <= '0;
            lane_ctrl   <= '0;
            lane_vld    <= 1'b0;
            fill_active <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= RUN;
                    lc_r    <= lc_legal_s;
                end
                RUN: begin
                    lane_sym    <= map_sym_s;
                    lane_ctrl   <= map_ctrl_s;
                    lane_vld    <= 1'b1;
                    fill_active <= empty_s;
                    if (empty_s) begin
                        underflow <= 1'b1;
                    end
                    if (drain_s) begin
                        sub_r <= last_sub_s ? SUB_W'(0) : (sub_r + SUB_W'(1));
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

endmodule
